// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 register-file completer: FSM states,
// response codes and the byte-strobe merge used by both the write port and read forwarding.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  // Widest legal bus; narrower callers zero-extend in and truncate out.
  localparam int APB_MAX_DW = 64;

  function automatic logic [APB_MAX_DW-1:0] apb_strb_merge(
    input logic [APB_MAX_DW-1:0]   old_data,
    input logic [APB_MAX_DW-1:0]   new_data,
    input logic [APB_MAX_DW/8-1:0] strb
  );
    logic [APB_MAX_DW-1:0] merged;
    for (int i = 0; i < APB_MAX_DW / 8; i++) begin
      merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb4_regfile_mem.sv
// DEPTH x DATA_WIDTH register array: async reset, one byte-enabled write port,
// one combinational read port (the top level registers the read result).
module apb4_regfile_mem
  import apb4_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter int                    MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [MEM_AW-1:0]       i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [MEM_AW-1:0]       i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_we && (i_waddr == MEM_AW'(i))) begin
          r_mem[i] <= DATA_WIDTH'(apb_strb_merge(APB_MAX_DW'(r_mem[i]),
                                                 APB_MAX_DW'(i_wdata),
                                                 (APB_MAX_DW/8)'(i_wstrb)));
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb4_regfile_slave.sv
// Parametrised APB4 register-file completer with byte strobes, programmable wait states
// and PSLVERR. Define APB_PROT_CHECK_EN to add PPROT and reject unprivileged upper-half writes.
module apb4_regfile_slave
  import apb4_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`ifdef APB_PROT_CHECK_EN
  input  logic [2:0]              PPROT,
`endif
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [IDX_W:0]        DEPTH_LIM  = (IDX_W+1)'(DEPTH);

  apb_state_e            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic                  r_ready;
  logic                  r_slverr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_setup;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_cur_write;
  logic [IDX_W-1:0]      w_cur_idx;
  logic [IDX_W-1:0]      w_commit_idx;
  logic                  w_commit;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_resp_data;

`ifdef APB_PROT_CHECK_EN
  localparam logic [IDX_W:0] PROT_LIM = (IDX_W+1)'(DEPTH / 2);
  logic r_priv;
  logic w_cur_priv;
  logic w_prot_err;
`endif

  assign w_setup      = PSELx && !PENABLE;
  assign w_commit     = (r_state == DONE) && r_write && (r_slverr == APB_RESP_OKAY);
  assign w_commit_idx = r_addr[ADDR_WIDTH-1:LSB];

  // Outside ACCESS the only transfer that can complete is a zero-wait one, whose
  // attributes are still on the bus rather than in the capture registers.
  always_comb begin
    w_cur_addr  = PADDR;
    w_cur_write = PWRITE;
    if (r_state == ACCESS) begin
      w_cur_addr  = r_addr;
      w_cur_write = r_write;
    end
  end

  assign w_cur_idx = w_cur_addr[ADDR_WIDTH-1:LSB];

`ifdef APB_PROT_CHECK_EN
  assign w_cur_priv = (r_state == ACCESS) ? r_priv : PPROT[0];
  assign w_prot_err = w_cur_write && !w_cur_priv && ({1'b0, w_cur_idx} >= PROT_LIM);
  assign w_err = (|(w_cur_addr & ALIGN_MASK)) || ({1'b0, w_cur_idx} >= DEPTH_LIM) || w_prot_err;
`else
  assign w_err = (|(w_cur_addr & ALIGN_MASK)) || ({1'b0, w_cur_idx} >= DEPTH_LIM);
`endif

  apb4_regfile_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .MEM_AW      (MEM_AW),
    .RESET_VALUE (RESET_VALUE)
  ) u_mem (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_we    (w_commit),
    .i_waddr (w_commit_idx[MEM_AW-1:0]),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_raddr (w_cur_idx[MEM_AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // A write committing on this edge must be visible to a read completing on the same edge.
  assign w_rd_data = (w_commit && (w_commit_idx == w_cur_idx))
                   ? DATA_WIDTH'(apb_strb_merge(APB_MAX_DW'(w_mem_rdata), APB_MAX_DW'(r_wdata),
                                                (APB_MAX_DW/8)'(r_strb)))
                   : w_mem_rdata;
  assign w_resp_data = (w_err || w_cur_write) ? '0 : w_rd_data;

  // r_cnt counts the PREADY-low cycles still to come, so DONE is entered as it leaves 1.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_ready  <= 1'b0;
      r_slverr <= APB_RESP_OKAY;
      r_rdata  <= '0;
`ifdef APB_PROT_CHECK_EN
      r_priv   <= 1'b0;
`endif
    end else begin
      r_ready  <= 1'b0;
      r_slverr <= APB_RESP_OKAY;
      r_rdata  <= '0;
      case (r_state)
        ACCESS: begin
          if (!PSELx || !PENABLE) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt <= 4'd1) begin
            r_state  <= DONE;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_slverr <= w_err ? APB_RESP_ERR : APB_RESP_OKAY;
            r_rdata  <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (w_setup) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
`ifdef APB_PROT_CHECK_EN
            r_priv  <= PPROT[0];
`endif
            if (WAIT_STATES == 0) begin
              r_state  <= DONE;
              r_cnt    <= '0;
              r_ready  <= 1'b1;
              r_slverr <= w_err ? APB_RESP_ERR : APB_RESP_OKAY;
              r_rdata  <= w_resp_data;
            end else begin
              r_state <= ACCESS;
              r_cnt   <= 4'(WAIT_STATES);
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;
  assign PRDATA  = r_rdata;

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Self-checking bench: two completers (2 wait states and 0 wait states) driven by directed
// and random APB transfers, checked every cycle against a word/byte-level register model.
module tb_apb4_regfile_slave;

  localparam int NDUT = 2;
`ifdef APB_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NDUT-1:0]       psel;
  logic [NDUT-1:0]       penable;
  logic [NDUT-1:0]       pwrite;
  logic [NDUT-1:0][11:0] paddr;
  logic [NDUT-1:0][31:0] pwdata;
  logic [NDUT-1:0][3:0]  pstrb;
  logic [NDUT-1:0][2:0]  pprot;
  logic [NDUT-1:0]       pready;
  logic [NDUT-1:0]       pslverr;
  logic [NDUT-1:0][31:0] prdata;

  int ws_of [NDUT] = '{2, 0};

  apb4_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .WAIT_STATES(2)) u_dut_ws2 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
`ifdef APB_PROT_CHECK_EN
    .PPROT(pprot[0]),
`endif
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb4_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSELx(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
`ifdef APB_PROT_CHECK_EN
    .PPROT(pprot[1]),
`endif
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  // Register model: one word per index, per DUT.
  logic [31:0] mdl [NDUT][16];

  bit [NDUT-1:0]       exp_ready = '0;
  bit [NDUT-1:0]       exp_err = '0;
  bit [NDUT-1:0]       exp_chk_rd = '0;
  logic [NDUT-1:0][31:0] exp_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int w = 0; w < NDUT; w++)
      for (int i = 0; i < 16; i++) mdl[w][i] = 32'h0;
  endtask

  // Outputs are all zero on every cycle except the completion cycle the driver announces.
  always @(negedge clk) begin
    for (int w = 0; w < NDUT; w++) begin
      check($sformatf("d%0d_pready", w), 64'(pready[w]), 64'(exp_ready[w]));
      check($sformatf("d%0d_pslverr", w), 64'(pslverr[w]), 64'(exp_err[w]));
      if (exp_chk_rd[w] || !exp_ready[w])
        check($sformatf("d%0d_prdata", w), 64'(prdata[w]), 64'(exp_rdata[w]));
      exp_ready[w]  = 1'b0;
      exp_err[w]    = 1'b0;
      exp_chk_rd[w] = 1'b0;
      exp_rdata[w]  = '0;
    end
  end

  task automatic idle(input int w, input int n);
    psel[w]    = 1'b0;
    penable[w] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Starts with the setup phase in the current cycle; returns after the completion
  // cycle's negedge, so a following call is a back-to-back transfer.
  task automatic xfer(input int w, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input int abort_k,
                      input int rst_k, output logic [31:0] got_rd, output logic got_err,
                      output int lat);
    int    ws;
    int    idx;
    bit    err;
    string tag;
    ws = ws_of[w];
    lat = -1;
    got_rd = '0;
    got_err = 1'b0;
    tag = "done";
    psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = addr;
    pwdata[w] = data; pstrb[w] = strb; pprot[w] = prot;
    @(posedge clk); #1;
    penable[w] = 1'b1;
    for (int k = 0; k <= ws; k++) begin
      if (k == abort_k) begin psel[w] = 1'b0; penable[w] = 1'b0; tag = "abort"; end
      if (k == rst_k) begin rst_n = 1'b0; psel[w] = 1'b0; penable[w] = 1'b0; tag = "reset"; end
      if (k == ws && tag == "done") begin
        idx = int'(addr >> 2);
        err = (addr[1:0] != 2'b00) || (idx >= 16) || (PROT_EN && wr && !prot[0] && idx >= 8);
        exp_ready[w]  = 1'b1;
        exp_err[w]    = err;
        exp_chk_rd[w] = !wr;
        exp_rdata[w]  = (!err && !wr) ? mdl[w][idx] : 32'h0;
        if (wr && !err)
          for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[w][idx][8*b +: 8] = data[8*b +: 8];
      end
      @(negedge clk);
      if (pready[w] && lat < 0) lat = k + 1;
      if (k == ws && tag == "done") begin
        got_rd  = prdata[w];
        got_err = pslverr[w];
      end
      if (tag != "done") break;
      if (k < ws) begin @(posedge clk); #1; end
    end
    if (tag == "abort") begin
      @(posedge clk); #1;
    end else if (tag == "reset") begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
    end
    $display("txn d%0d %s %s addr=0x%03h wdata=0x%08h strb=%b prot=%b rdata=0x%08h err=%0d lat=%0d",
             w, wr ? "WR" : "RD", tag, addr, data, strb, prot, got_rd, got_err, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    rst_n = 1'b0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset contents and wait-state latency
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 12'(i * 4), 32'h0, 4'h0, 3'b000, -1, -1, rd, er, lt);
      check($sformatf("t1_rd%0d", i), 64'(rd), 64'h0);
      check($sformatf("t1_err%0d", i), 64'(er), 64'h0);
      check($sformatf("t1_lat%0d", i), 64'(lt), 64'd3);
      idle(0, 1);
    end

    // Strobed writes
    xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, 4'b1111, 3'b001, -1, -1, rd, er, lt);
    xfer(0, 1'b1, 12'h008, 32'h11223344, 4'b0101, 3'b001, -1, -1, rd, er, lt);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t2_rd", 64'(rd), 64'hDE22BE44);
    check("t2_model", 64'(mdl[0][2]), 64'hDE22BE44);
    idle(0, 1);

    // Error responses
    xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t3_oor_err", 64'(er), 64'h1);
    check("t3_oor_rd", 64'(rd), 64'h0);
    xfer(0, 1'b1, 12'h00A, 32'hCAFEF00D, 4'b1111, 3'b001, -1, -1, rd, er, lt);
    check("t3_mis_err", 64'(er), 64'h1);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t3_unchanged", 64'(rd), 64'hDE22BE44);
    idle(0, 1);

    // Zero-wait back-to-back write then read
    xfer(1, 1'b1, 12'h004, 32'hA5A5A5A5, 4'b1111, 3'b001, -1, -1, rd, er, lt);
    check("t4_wr_lat", 64'(lt), 64'd1);
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t4_rd_lat", 64'(lt), 64'd1);
    check("t4_rd", 64'(rd), 64'hA5A5A5A5);
    idle(1, 1);

    // Abort during a wait state
    xfer(0, 1'b1, 12'h00C, 32'h12345678, 4'b1111, 3'b001, 1, -1, rd, er, lt);
    check("t5_abort_noready", 64'(lt), 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t5_abort_nowrite", 64'(rd), 64'h0);
    idle(0, 1);

    // Reset during a wait state
    xfer(0, 1'b1, 12'h010, 32'h77777777, 4'b1111, 3'b001, -1, 1, rd, er, lt);
    check("t5_rst_noready", 64'(lt), 64'hFFFF_FFFF_FFFF_FFFF);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t5_rst_rd10", 64'(rd), 64'h0);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b001, -1, -1, rd, er, lt);
    check("t5_rst_rd08", 64'(rd), 64'h0);
    idle(0, 1);

`ifdef APB_PROT_CHECK_EN
    xfer(0, 1'b1, 12'h020, 32'h1, 4'b1111, 3'b000, -1, -1, rd, er, lt);
    check("t6_unpriv_err", 64'(er), 64'h1);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 3'b000, -1, -1, rd, er, lt);
    check("t6_unpriv_rd", 64'(rd), 64'h0);
    xfer(0, 1'b1, 12'h020, 32'h1, 4'b1111, 3'b001, -1, -1, rd, er, lt);
    check("t6_priv_err", 64'(er), 64'h0);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 3'b000, -1, -1, rd, er, lt);
    check("t6_priv_rd", 64'(rd), 64'h1);
    idle(0, 1);
`endif

    // Random traffic; the per-cycle compare process does the checking
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < ((p == 0) ? 120 : 80); n++) begin
        int          sel;
        int          abort_k;
        int          gap;
        logic [11:0] addr;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      addr = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (sel == 1) addr = 12'($urandom_range(16, 1023) * 4);
        else               addr = 12'($urandom_range(0, 15) * 4);
        abort_k = (p == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
        xfer(p, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), abort_k, -1, rd, er, lt);
        gap = int'($urandom_range(0, 2));
        if (gap > 0) idle(p, gap);
      end
      idle(p, 2);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
